// File: rtl/imem_pkg.sv
// Shared constants, FSM state type and sizing helpers for the loadable instruction memory.
package imem_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SVPC = 4'b1111;

  typedef enum logic [1:0] {
    StClear,
    StIdle,
    StLoad
  } imem_state_e;

  function automatic int unsigned beats_per_word(int unsigned data_w, int unsigned load_w);
    return data_w / load_w;
  endfunction

endpackage

// File: rtl/imem_word_asm.sv
// Assembles MSB-first load beats into full instruction words; flags the completing beat.
module imem_word_asm
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LOAD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              beat_valid_i,
  input  logic [LOAD_W-1:0] beat_i,
  output logic [DATA_W-1:0] word_o,
  output logic              word_valid_o
);

  localparam int unsigned Bpw  = beats_per_word(DATA_W, LOAD_W);
  localparam int unsigned CntW = (Bpw > 1) ? $clog2(Bpw) : 1;
  localparam int unsigned SrW  = (Bpw > 1) ? DATA_W - LOAD_W : 1;

  logic [SrW-1:0]  sr_q, sr_d, sr_shift;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            last_beat;

  // sr_q only holds the earlier beats; the final beat is taken straight from the port.
  if (Bpw > 1) begin : g_multi
    assign word_o   = {sr_q, beat_i};
    assign sr_shift = word_o[SrW-1:0];
  end else begin : g_single
    assign word_o   = beat_i;
    assign sr_shift = sr_q;
  end

  assign last_beat    = beat_valid_i && (cnt_q == CntW'(Bpw - 1));
  assign word_valid_o = last_beat;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (beat_valid_i) begin
      sr_d  = sr_shift;
      cnt_d = last_beat ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_imem.sv
// Loadable instruction memory: registered fetch port, byte-serial load port, NOP clear after reset.
module prog_imem
  import imem_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 256,
  parameter int unsigned       ADDR_W   = $clog2(DEPTH),
  parameter int unsigned       LOAD_W   = 8,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(imem_pkg::NOP_WORD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic [31:0]       pc,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              instr_oob,
  output logic              busy,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [LOAD_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              ld_abort,
  output logic              ld_done,
  output logic              ld_err
);

  if ((DATA_W % LOAD_W) != 0) begin : g_bad_load_w
    $error("prog_imem: DATA_W must be a multiple of LOAD_W");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];

  imem_state_e       state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W:0]   left_q, left_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              instr_oob_q, instr_oob_d;
  logic              ld_done_q, ld_done_d;
  logic              ld_err_q, ld_err_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              asm_clear, asm_beat, asm_word_valid;
  logic [DATA_W-1:0] asm_word;
  logic              pc_in_range;
  logic [ADDR_W+1:0] ld_end;

  assign pc_in_range = pc < 32'(DEPTH);
  assign ld_end      = (ADDR_W + 2)'(ld_base) + (ADDR_W + 2)'(ld_len);
  // Abort wins over a same-cycle beat, so the beat never reaches the assembler.
  assign asm_beat    = ld_valid && (state_q == StLoad) && !ld_abort;

  imem_word_asm #(
    .DATA_W(DATA_W),
    .LOAD_W(LOAD_W)
  ) u_word_asm (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (asm_clear),
    .beat_valid_i (asm_beat),
    .beat_i       (ld_data),
    .word_o       (asm_word),
    .word_valid_o (asm_word_valid)
  );

  always_comb begin
    state_d       = state_q;
    clr_ptr_d     = clr_ptr_q;
    wptr_d        = wptr_q;
    left_d        = left_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    instr_oob_d   = 1'b0;
    ld_done_d     = 1'b0;
    ld_err_d      = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = wptr_q;
    mem_wdata     = asm_word;
    asm_clear     = 1'b0;
    unique case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_addr  = clr_ptr_q;
        mem_wdata = NOP_WORD;
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
          clr_ptr_d = '0;
          state_d   = StIdle;
        end
      end
      StIdle: begin
        if (fetch_en) begin
          instr_valid_d = 1'b1;
          instr_oob_d   = !pc_in_range;
          instr_d       = pc_in_range ? mem_q[pc[ADDR_W-1:0]] : NOP_WORD;
        end
        if (ld_start) begin
          if (ld_len == '0) begin
            ld_done_d = 1'b1;
          end else if (ld_end > (ADDR_W + 2)'(DEPTH)) begin
            ld_err_d = 1'b1;
          end else begin
            wptr_d  = ld_base;
            left_d  = ld_len;
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (ld_abort) begin
          asm_clear = 1'b1;
          ld_err_d  = 1'b1;
          state_d   = StIdle;
        end else if (asm_word_valid) begin
          mem_we = 1'b1;
          wptr_d = wptr_q + ADDR_W'(1);
          left_d = left_q - (ADDR_W + 1)'(1);
          if (left_q == (ADDR_W + 1)'(1)) begin
            ld_done_d = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StClear;
      clr_ptr_q     <= '0;
      wptr_q        <= '0;
      left_q        <= '0;
      instr_q       <= NOP_WORD;
      instr_valid_q <= 1'b0;
      instr_oob_q   <= 1'b0;
      ld_done_q     <= 1'b0;
      ld_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_ptr_q     <= clr_ptr_d;
      wptr_q        <= wptr_d;
      left_q        <= left_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      instr_oob_q   <= instr_oob_d;
      ld_done_q     <= ld_done_d;
      ld_err_q      <= ld_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign instr_oob   = instr_oob_q;
  assign ld_done     = ld_done_q;
  assign ld_err      = ld_err_q;
  assign busy        = (state_q != StIdle);
  assign ld_ready    = (state_q == StLoad);

endmodule

// File: tb/tb_prog_imem.sv
// Randomised bench for prog_imem against an array-based reference model of memory contents.
module tb_prog_imem;

  localparam int unsigned DataW = 32;
  localparam int unsigned Depth = 256;
  localparam int unsigned AddrW = 8;
  localparam int unsigned LoadW = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             fetch_en;
  logic [31:0]      pc;
  logic [DataW-1:0] instr;
  logic             instr_valid, instr_oob, busy;
  logic             ld_start;
  logic [AddrW-1:0] ld_base;
  logic [AddrW:0]   ld_len;
  logic             ld_valid;
  logic [LoadW-1:0] ld_data;
  logic             ld_ready, ld_abort, ld_done, ld_err;

  always #5 clk = ~clk;

  prog_imem #(
    .DATA_W   (DataW),
    .DEPTH    (Depth),
    .ADDR_W   (AddrW),
    .LOAD_W   (LoadW),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_oob   (instr_oob),
    .busy        (busy),
    .ld_start    (ld_start),
    .ld_base     (ld_base),
    .ld_len      (ld_len),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .ld_abort    (ld_abort),
    .ld_done     (ld_done),
    .ld_err      (ld_err)
  );

  logic [31:0] model_mem [Depth];
  logic [31:0] ld_words [$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < Depth; i++) model_mem[i] = 32'h0;
  endtask

  // Counts busy cycles after reset release while poking ignored requests.
  task automatic wait_clear();
    int n;
    bit stray;
    n = 0;
    stray = 1'b0;
    fetch_en = 1'b1;
    pc = 32'd3;
    ld_start = 1'b1;
    ld_base = 8'd0;
    ld_len = 9'd1;
    while (busy && n < 2000) begin
      tick();
      n++;
      if (instr_valid || ld_done || ld_err || ld_ready) stray = 1'b1;
    end
    fetch_en = 1'b0;
    ld_start = 1'b0;
    check_eq("clear_cycles", n, Depth);
    check_eq("clear_ignores_req", stray, 0);
    tick();
    check_eq("after_clear_busy", busy, 0);
    check_eq("after_clear_ready", ld_ready, 0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check_eq("rst_busy", busy, 1);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_valid", instr_valid, 0);
    check_eq("rst_oob", instr_oob, 0);
    check_eq("rst_ready", ld_ready, 0);
    check_eq("rst_done", ld_done, 0);
    check_eq("rst_err", ld_err, 0);
    tick();
    tick();
    rst = 1'b0;
    model_clear();
    wait_clear();
  endtask

  task automatic do_fetch(input logic [31:0] addr);
    logic [31:0] exp;
    logic        oob;
    oob = (addr >= Depth);
    exp = oob ? 32'h0 : model_mem[addr[AddrW-1:0]];
    fetch_en = 1'b1;
    pc = addr;
    tick();
    fetch_en = 1'b0;
    check_eq("fetch_instr", instr, exp);
    check_eq("fetch_valid", instr_valid, 1);
    check_eq("fetch_oob", instr_oob, oob);
    tick();
    check_eq("fetch_valid_drop", instr_valid, 0);
  endtask

  // Loads ld_words at base; abort_at >= 0 asserts ld_abort alongside that beat index.
  task automatic do_load(input int base, input int len, input int abort_at, input bit gaps);
    logic [31:0] w;
    logic [31:0] held;
    bit          last;
    int          nbeats;
    ld_start = 1'b1;
    ld_base = AddrW'(base);
    ld_len = (AddrW + 1)'(len);
    tick();
    ld_start = 1'b0;
    if (len == 0) begin
      check_eq("len0_done", ld_done, 1);
      check_eq("len0_err", ld_err, 0);
      check_eq("len0_busy", busy, 0);
      tick();
      check_eq("len0_done_pulse", ld_done, 0);
      return;
    end
    if (base + len > Depth) begin
      check_eq("range_err", ld_err, 1);
      check_eq("range_done", ld_done, 0);
      check_eq("range_busy", busy, 0);
      tick();
      check_eq("range_err_pulse", ld_err, 0);
      return;
    end
    check_eq("load_busy", busy, 1);
    check_eq("load_ready", ld_ready, 1);
    held = instr;
    nbeats = len * (DataW / LoadW);
    for (int i = 0; i < nbeats; i++) begin
      w = ld_words[i / 4];
      if (i == abort_at) begin
        ld_abort = 1'b1;
        ld_valid = 1'b1;
        ld_data = w[31 - 8 * (i % 4) -: 8];
        tick();
        ld_abort = 1'b0;
        ld_valid = 1'b0;
        check_eq("abort_err", ld_err, 1);
        check_eq("abort_done", ld_done, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_ready", ld_ready, 0);
        tick();
        check_eq("abort_err_pulse", ld_err, 0);
        return;
      end
      if (gaps && (i == 3 || $urandom_range(0, 3) == 0)) begin
        ld_valid = 1'b0;
        fetch_en = 1'b1;
        pc = $urandom_range(0, 255);
        tick();
        fetch_en = 1'b0;
        check_eq("gap_done", ld_done, 0);
        check_eq("gap_busy", busy, 1);
        check_eq("stall_valid", instr_valid, 0);
        check_eq("stall_hold", instr, held);
      end
      ld_valid = 1'b1;
      ld_data = w[31 - 8 * (i % 4) -: 8];
      fetch_en = 1'($urandom_range(0, 1));
      tick();
      ld_valid = 1'b0;
      fetch_en = 1'b0;
      if (i % 4 == 3) model_mem[base + i / 4] = w;
      last = (i == nbeats - 1);
      check_eq("beat_done", ld_done, last);
      check_eq("beat_busy", busy, !last);
      check_eq("beat_valid", instr_valid, 0);
    end
    tick();
    check_eq("done_pulse", ld_done, 0);
  endtask

  task automatic fill_words(input int len);
    ld_words.delete();
    for (int k = 0; k < len; k++) ld_words.push_back($urandom());
  endtask

  initial begin
    int          base;
    int          len;
    logic [31:0] w;
    rst = 1'b1;
    fetch_en = 1'b0;
    pc = '0;
    ld_start = 1'b0;
    ld_base = '0;
    ld_len = '0;
    ld_valid = 1'b0;
    ld_data = '0;
    ld_abort = 1'b0;

    apply_reset();
    do_fetch(32'd5);

    ld_words.delete();
    ld_words.push_back(32'h4104_0800);
    ld_words.push_back(32'h6041_0000);
    do_load(0, 2, -1, 1'b1);
    do_fetch(32'd0);
    do_fetch(32'd1);

    do_load(250, 10, -1, 1'b0);
    do_fetch(32'd250);
    do_load(7, 0, -1, 1'b0);

    fill_words(2);
    do_load(4, 2, 5, 1'b0);
    do_fetch(32'd4);
    do_fetch(32'd5);

    // Fetch and load start in the same cycle: fetch uses old contents.
    fetch_en = 1'b1;
    pc = 32'd300;
    ld_start = 1'b1;
    ld_base = 8'd0;
    ld_len = 9'd1;
    tick();
    fetch_en = 1'b0;
    ld_start = 1'b0;
    check_eq("same_instr", instr, 32'h0);
    check_eq("same_oob", instr_oob, 1);
    check_eq("same_valid", instr_valid, 1);
    check_eq("same_busy", busy, 1);
    check_eq("same_ready", ld_ready, 1);
    w = $urandom();
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1;
      ld_data = w[31 - 8 * i -: 8];
      tick();
    end
    ld_valid = 1'b0;
    model_mem[0] = w;
    check_eq("same_done", ld_done, 1);
    tick();
    do_fetch(32'd0);
    do_fetch(32'd1);

    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 9) < 6) begin
        base = ($urandom_range(0, 1) == 1) ? $urandom_range(250, 255) : $urandom_range(0, 255);
        len = $urandom_range(0, 4);
        fill_words(len);
        do_load(base, len, ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : -1, 1'b1);
      end else begin
        do_fetch($urandom_range(0, 300));
      end
    end
    for (int a = 250; a < 256; a++) do_fetch(a);
    do_fetch(32'd256);

    // Reset partway through a load re-clears everything.
    ld_start = 1'b1;
    ld_base = 8'd1;
    ld_len = 9'd1;
    tick();
    ld_start = 1'b0;
    w = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_data = w[31 - 8 * i -: 8];
      tick();
    end
    ld_valid = 1'b0;
    apply_reset();
    do_fetch(32'd0);
    do_fetch(32'd1);
    do_fetch(32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_imem.md
Name: prog_imem

Overview:
Parametrised, loadable instruction memory for the pipelined CPU. It replaces a fixed, initial-block-filled ROM with a clocked fetch port plus a byte-serial program-load port, so programs are written at run time instead of being compiled into the memory. After reset, a hardware clear sequence fills every location with NOP. The block sits between the fetch stage (PC in, instruction out) and the test/boot loader.

Parameters:
DATA_W, 32, instruction word width in bits
DEPTH, 256, number of instruction words
ADDR_W, $clog2(DEPTH), internal word-index width
LOAD_W, 8, load-port beat width; DATA_W % LOAD_W == 0, checked at elaboration
NOP_WORD, 32'h0000_0000, fill and out-of-range value (opcode 0000 = NOP)

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  asynchronous, active-high reset
fetch_en  in  1  fetch request
pc  in  32  word address (PC indexes words directly)
instr  out  DATA_W  registered instruction
instr_valid  out  1  instr updated by a fetch this cycle
instr_oob  out  1  last fetch had pc >= DEPTH
busy  out  1  clear or load in progress; fetch stalls
ld_start  in  1  start-load pulse
ld_base  in  ADDR_W  first word index to write
ld_len  in  ADDR_W+1  number of words to load
ld_valid  in  1  ld_data beat valid
ld_data  in  LOAD_W  load beat; MSB-first within a word
ld_ready  out  1  block accepts a beat
ld_abort  in  1  cancel the active load
ld_done  out  1  one-cycle pulse: load completed
ld_err  out  1  one-cycle pulse: load rejected or aborted

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=CLEAR, clr_ptr=0, instr=NOP_WORD, instr_valid=0, instr_oob=0, busy=1, ld_ready=0, ld_done=0, ld_err=0, beat count=0.
- States: CLEAR, IDLE, LOAD.
- CLEAR:
  - Each cycle: mem[clr_ptr] <= NOP_WORD, clr_ptr++.
  - After the write to index DEPTH-1, go to IDLE. busy is high for exactly DEPTH cycles after rst deasserts.
  - fetch_en and ld_start are ignored.
- IDLE, busy=0:
  - fetch_en=1: the next cycle has instr = mem[pc] if pc < DEPTH, else NOP_WORD with instr_oob=1. instr_valid=1 for one cycle. Latency is 1 cycle.
  - fetch_en=0: instr holds its value; instr_valid=0; instr_oob=0.
- ld_start in IDLE:
  - ld_len==0: ld_done pulses next cycle; no writes; stay in IDLE.
  - ld_base+ld_len > DEPTH: ld_err pulses next cycle; no writes; stay in IDLE.
  - Otherwise: latch wptr=ld_base and words_left=ld_len, then go to LOAD.
  - fetch_en and ld_start in the same cycle: the fetch is served from the old contents, and the load starts next cycle.
- LOAD, busy=1, ld_ready=1:
  - A beat is accepted when ld_valid && ld_ready. It is shifted into the assembly register: asm <= {asm[DATA_W-LOAD_W-1:0], ld_data}.
  - On the DATA_W/LOAD_W-th accepted beat: mem[wptr] <= the assembled word, wptr++, words_left--, and the beat count resets.
  - Gaps in ld_valid are allowed; nothing advances while ld_valid=0.
  - After the final word is written: ld_done pulses next cycle; go to IDLE, with busy=0 and ld_ready=0 from that cycle.
  - fetch_en in LOAD: instr holds, instr_valid=0 (the CPU must stall on busy).
  - ld_start in LOAD is ignored.
- ld_abort in LOAD (has priority over a same-cycle beat):
  - Go to IDLE and pulse ld_err.
  - The partial word is discarded. Words already written are kept; the rest are unchanged.
- Reading and writing the same location is impossible by construction, because fetch is blocked during writes.
- rst mid-load or mid-clear: immediate return to CLEAR, and the whole memory is re-cleared.
- Memory array has no reset; only the CLEAR sequence initialises it.

Decomposition:
- Package imem_pkg holds:
  - NOP_WORD and the opcode constants (NOP=4'b0000, ADD=4'b0100, SVPC=4'b1111, etc.)
  - the state enum {CLEAR, IDLE, LOAD}
  - the helper function beats_per_word(DATA_W, LOAD_W)
- Sub-module imem_word_asm is the beat shift register and beat counter. It outputs word and word_valid, and has a clear input driven on abort.
- The memory array and FSM stay in prog_imem.

Test Plan:
- Release rst → busy=1 for 256 cycles, then 0. Then fetch_en with pc=5 → next cycle instr=32'h0, instr_valid=1.
- ld_start base=0 len=2, then beats 41,04,08,00,60,41,00,00 (hex) with one idle gap → ld_done after the 8th beat. Then fetch pc=0 → 32'h41040800 and pc=1 → 32'h60410000.
- ld_start base=250 len=10 → ld_err one cycle; busy stays 0. Fetch pc=250 → 32'h0.
- Load base=4 len=2, ld_abort after 5 beats → ld_err. mem[4] holds the first word; mem[5] stays 32'h0.
- fetch pc=300 → instr=32'h0, instr_oob=1, instr_valid=1. Same cycle as ld_start base=0 len=1 → fetch served first, and the load begins next cycle.
- Assert rst after 3 beats of a load → busy=1, 256-cycle clear. Then fetch pc=0 returns 32'h0.
